// File: rtl/relm_sram_arbiter.sv
// rtl/relm_sram_arbiter.sv - round-robin arbiter sharing one SRAM among NREQ ReLM I/O requesters
module relm_sram_arbiter #(
    parameter int NREQ  = 4,
    parameter int WAD   = 16,
    parameter int WD    = 32,
    parameter int RDLAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ*(WD+3)-1:0]   cmd_in,
    output logic [NREQ-1:0]          retry_out,
    output logic [NREQ*(WD+1)-1:0]   rd_out,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [WAD-1:0]           mem_ad,
    output logic [WD-1:0]            mem_d,
    input  logic [WD-1:0]            mem_q
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] OP_SETAD = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    logic [NREQ-1:0] req_v;
    logic [1:0]      req_op [NREQ];
    logic [WD-1:0]   req_pl [NREQ];
    logic [NREQ-1:0] is_mem;

    logic [GW-1:0]   rr;
    logic [GW-1:0]   gnt_idx;
    logic            gnt_v;
    logic [WAD-1:0]  ptr [NREQ];

    logic [GW-1:0]   iss_g;
    logic [RDLAT-1:0] pipe_v;
    logic [GW-1:0]   pipe_g [RDLAT];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_v[i]  = cmd_in[i*(WD+3) + WD + 2];
            req_op[i] = cmd_in[i*(WD+3) + WD +: 2];
            req_pl[i] = cmd_in[i*(WD+3) +: WD];
            is_mem[i] = req_v[i] && (req_op[i] == OP_WRITE || req_op[i] == OP_READ);
        end
    end

    // Scan starts at rr; nothing is granted while reset is held, so every memory command retries.
    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = rr;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(rr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_v && is_mem[j]) begin
                gnt_v   = 1'b1;
                gnt_idx = GW'(j);
            end
        end
        if (!rst_n) gnt_v = 1'b0;
        retry_out = is_mem;
        if (gnt_v) retry_out[gnt_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= '0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            mem_ad <= '0;
            mem_d  <= '0;
            iss_g  <= '0;
            pipe_v <= '0;
            rd_out <= '0;
            for (int i = 0; i < NREQ; i++) ptr[i] <= '0;
            for (int s = 0; s < RDLAT; s++) pipe_g[s] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_v[i] && req_op[i] == OP_SETAD) ptr[i] <= req_pl[i][WAD-1:0];
            end
            mem_we <= gnt_v && (req_op[gnt_idx] == OP_WRITE);
            mem_re <= gnt_v && (req_op[gnt_idx] == OP_READ);
            if (gnt_v) begin
                rr           <= (gnt_idx == GW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                ptr[gnt_idx] <= ptr[gnt_idx] + 1'b1;
                mem_ad       <= ptr[gnt_idx];
                iss_g        <= gnt_idx;
                if (req_op[gnt_idx] == OP_WRITE) mem_d <= req_pl[gnt_idx];
            end
            // Tag travels alongside the SRAM read so the return lands on the right channel.
            pipe_v[0] <= mem_re;
            pipe_g[0] <= iss_g;
            for (int s = 1; s < RDLAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_g[s] <= pipe_g[s-1];
            end
            rd_out <= '0;
            if (pipe_v[RDLAT-1])
                rd_out[int'(pipe_g[RDLAT-1])*(WD+1) +: WD+1] <= {1'b1, mem_q};
        end
    end
endmodule

// File: tb/tb_relm_sram_arbiter.sv
// tb/tb_relm_sram_arbiter.sv - scoreboard bench for relm_sram_arbiter
module tb_relm_sram_arbiter;
    localparam int NREQ = 4, WAD = 16, WD = 32, RDLAT = 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ*(WD+3)-1:0] cmd_in;
    logic [NREQ-1:0]        retry_out;
    logic [NREQ*(WD+1)-1:0] rd_out;
    logic                   mem_we, mem_re;
    logic [WAD-1:0]         mem_ad;
    logic [WD-1:0]          mem_d, mem_q;

    always #5 clk = ~clk;

    relm_sram_arbiter #(.NREQ(NREQ), .WAD(WAD), .WD(WD), .RDLAT(RDLAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .retry_out(retry_out), .rd_out(rd_out),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ad(mem_ad), .mem_d(mem_d), .mem_q(mem_q)
    );

    // SRAM model: write visible to a read issued the following cycle
    logic [WD-1:0] sram [0:(1<<WAD)-1];
    logic [WD-1:0] q_pipe [RDLAT];
    always @(posedge clk) begin
        if (mem_re) q_pipe[0] <= sram[mem_ad];
        for (int s = 1; s < RDLAT; s++) q_pipe[s] <= q_pipe[s-1];
        if (mem_we) sram[mem_ad] = mem_d;
    end
    assign mem_q = q_pipe[RDLAT-1];

    logic          c_v  [NREQ];
    logic [1:0]    c_op [NREQ];
    logic [WD-1:0] c_pl [NREQ];
    always_comb begin
        cmd_in = '0;
        for (int i = 0; i < NREQ; i++) cmd_in[i*(WD+3) +: WD+3] = {c_v[i], c_op[i], c_pl[i]};
    end

    int n_checks = 0, n_errors = 0;
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { int due; logic we; logic re; logic [WAD-1:0] ad; logic [WD-1:0] d; } iss_t;
    typedef struct { int due; int r; logic [WD-1:0] d; } ret_t;

    logic [WD+1:0]  scr [NREQ][$];
    iss_t           iss_q [$];
    ret_t           rd_q [$];
    logic [WD-1:0]  smem [0:(1<<WAD)-1];
    logic [WAD-1:0] ptr_m [NREQ];
    int             rr_m = 0, cyc = 0;
    logic [WAD-1:0] last_ad = '0;
    logic [WD-1:0]  last_d = '0;

    // Reference model: checks registered outputs due now, then predicts this cycle's arbitration
    always @(negedge clk) begin
        iss_t ie;
        ret_t re;
        int g;
        logic exp_we, exp_re;
        logic [NREQ-1:0] ism, eretry, erv;
        logic [WD-1:0] erd [NREQ];
        if (!rst_n) begin
            rr_m = 0;
            for (int i = 0; i < NREQ; i++) ptr_m[i] = '0;
            iss_q.delete();
            rd_q.delete();
            last_ad = '0;
            last_d  = '0;
        end
        exp_we = 1'b0;
        exp_re = 1'b0;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            ie = iss_q.pop_front();
            exp_we = ie.we;
            exp_re = ie.re;
            last_ad = ie.ad;
            if (ie.we) last_d = ie.d;
        end
        check_eq("mem_we", mem_we, exp_we);
        check_eq("mem_re", mem_re, exp_re);
        check_eq("mem_ad", mem_ad, last_ad);
        check_eq("mem_d", mem_d, last_d);
        erv = '0;
        for (int i = 0; i < NREQ; i++) erd[i] = '0;
        while (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            re = rd_q.pop_front();
            erv[re.r] = 1'b1;
            erd[re.r] = re.d;
        end
        for (int i = 0; i < NREQ; i++) begin
            check_eq($sformatf("rd_valid%0d", i), rd_out[i*(WD+1)+WD], erv[i]);
            if (erv[i]) check_eq($sformatf("rd_data%0d", i), rd_out[i*(WD+1) +: WD], erd[i]);
        end
        for (int i = 0; i < NREQ; i++) ism[i] = c_v[i] && (c_op[i] == 2'b01 || c_op[i] == 2'b10);
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && ism[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
        if (!rst_n) g = -1;
        eretry = ism;
        if (g >= 0) eretry[g] = 1'b0;
        check_eq("retry_out", retry_out, eretry);
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++)
                if (c_v[i] && c_op[i] == 2'b00) ptr_m[i] = c_pl[i][WAD-1:0];
            if (g >= 0) begin
                ie.due = cyc + 1; ie.ad = ptr_m[g]; ie.d = c_pl[g];
                ie.we = (c_op[g] == 2'b01); ie.re = (c_op[g] == 2'b10);
                iss_q.push_back(ie);
                if (ie.we) smem[ptr_m[g]] = c_pl[g];
                else begin
                    re.due = cyc + 2 + RDLAT; re.r = g; re.d = smem[ptr_m[g]];
                    rd_q.push_back(re);
                end
                ptr_m[g] = ptr_m[g] + 1'b1;
                rr_m = (g + 1) % NREQ;
            end
            for (int i = 0; i < NREQ; i++)
                if (c_v[i] && !eretry[i] && scr[i].size() > 0) void'(scr[i].pop_front());
        end
        cyc++;
    end

    task automatic push(input int r, input logic [1:0] op, input logic [WD-1:0] pl);
        scr[r].push_back({op, pl});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            c_v[i] = (scr[i].size() > 0);
            if (c_v[i]) begin
                c_op[i] = scr[i][0][WD+1:WD];
                c_pl[i] = scr[i][0][WD-1:0];
            end else begin
                c_op[i] = 2'b00;
                c_pl[i] = '0;
            end
        end
    endtask

    function automatic int pending();
        int n;
        n = iss_q.size() + rd_q.size();
        for (int i = 0; i < NREQ; i++) n += scr[i].size();
        return n;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (pending() > 0 && n < maxc) begin
            tick();
            n++;
        end
        tick();
        check_eq("drain_pending", pending(), 0);
    endtask

    initial begin
        for (int a = 0; a < (1 << WAD); a++) begin
            sram[a] = '0;
            smem[a] = '0;
        end
        for (int s = 0; s < RDLAT; s++) q_pipe[s] = '0;
        for (int i = 0; i < NREQ; i++) begin
            c_v[i] = 1'b0; c_op[i] = 2'b00; c_pl[i] = '0;
        end
        // reset with all requesters valid, then first grant must go to req0
        push(0, 2'b10, 0); push(1, 2'b01, 32'h77); push(2, 2'b00, 32'h20); push(3, 2'b11, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        drain(50);
        // single requester write/read-back
        push(0, 2'b00, 32'h10); push(0, 2'b01, 32'hA); push(0, 2'b01, 32'hB);
        push(0, 2'b00, 32'h10); push(0, 2'b10, 0); push(0, 2'b10, 0);
        drain(50);
        // all four requesters: fill distinct regions, then continuous reads
        for (int r = 0; r < NREQ; r++) begin
            push(r, 2'b00, 32'h200 + r * 16);
            for (int k = 0; k < 4; k++) push(r, 2'b01, 32'h1000 + r * 16 + k);
        end
        drain(100);
        for (int r = 0; r < NREQ; r++) begin
            push(r, 2'b00, 32'h200 + r * 16);
            for (int k = 0; k < 4; k++) push(r, 2'b10, 0);
        end
        drain(100);
        // same-cycle SETAD and WRITE from different requesters
        push(1, 2'b00, 32'h0100); push(2, 2'b01, 32'h55);
        drain(20);
        // pointer wrap
        push(3, 2'b00, 32'hFFFF); push(3, 2'b01, 32'h1); push(3, 2'b01, 32'h2);
        push(3, 2'b00, 32'hFFFF); push(3, 2'b10, 0); push(3, 2'b10, 0);
        drain(30);
        // mixed random traffic over a small address window
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < 12; k++) begin
                logic [1:0] op;
                op = 2'($urandom_range(0, 3));
                push(r, op, (op == 2'b00) ? 32'($urandom_range(0, 15)) : 32'($urandom));
            end
        drain(300);
        // reset one cycle before a read return drops it and clears rr/pointers
        push(0, 2'b10, 0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < NREQ; r++) push(r, 2'b10, 0);
        drain(50);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
